// File: rtl/sc_pc_sequencer.sv
// sc_pc_sequencer
// Program-counter stage fed by the fixed increment register. Holds the
// current PC and, on every falling clock edge, selects the next PC from
// hold / sequential step / PC-relative branch / absolute jump / trap vector.
// Every loaded PC is forced word aligned; a misaligned raw target raises a
// sticky error flag.
//
// Ports:
//   SC_PCSeq_CLOCK_50          clock, registers update on the falling edge
//   SC_RegGENERAL_RESET_InHigh asynchronous active-high reset
//   SC_PCSeq_Step_In           increment constant (normally 4)
//   SC_PCSeq_Disp_In           signed word displacement for branches
//   SC_PCSeq_Target_In         absolute jump target
//   SC_PCSeq_Sel_In            00 hold, 01 step, 10 branch, 11 jump
//   SC_PCSeq_Stall_In          freeze PC/count (trap still wins)
//   SC_PCSeq_Trap_In           load the trap vector
//   SC_PCSeq_ClrErr_In         clear the misalignment flag
//   SC_PCSeq_PC_Out            registered current PC
//   SC_PCSeq_PCNext_Out        combinational PC + Step (link value)
//   SC_PCSeq_Changed_Out       high for one cycle after an accepted load
//   SC_PCSeq_Misalign_Out      sticky misalignment flag
//   SC_PCSeq_Count_Out         saturating accepted-load counter
module sc_pc_sequencer #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_DISP = 22,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [DATAWIDTH_BUS-1:0] TRAP_VECTOR  = 32'h00000800
) (
  input  logic                      SC_PCSeq_CLOCK_50,
  input  logic                      SC_RegGENERAL_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]  SC_PCSeq_Step_In,
  input  logic [DATAWIDTH_DISP-1:0] SC_PCSeq_Disp_In,
  input  logic [DATAWIDTH_BUS-1:0]  SC_PCSeq_Target_In,
  input  logic [1:0]                SC_PCSeq_Sel_In,
  input  logic                      SC_PCSeq_Stall_In,
  input  logic                      SC_PCSeq_Trap_In,
  input  logic                      SC_PCSeq_ClrErr_In,
  output logic [DATAWIDTH_BUS-1:0]  SC_PCSeq_PC_Out,
  output logic [DATAWIDTH_BUS-1:0]  SC_PCSeq_PCNext_Out,
  output logic                      SC_PCSeq_Changed_Out,
  output logic                      SC_PCSeq_Misalign_Out,
  output logic [15:0]               SC_PCSeq_Count_Out
);

  localparam logic [1:0] SEL_HOLD   = 2'b00;
  localparam logic [1:0] SEL_STEP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_JUMP   = 2'b11;

  // Trap vector is aligned even if the parameter is not.
  localparam logic [DATAWIDTH_BUS-1:0] TRAP_ALIGNED = {TRAP_VECTOR[DATAWIDTH_BUS-1:2], 2'b00};

  logic [DATAWIDTH_BUS-1:0] pcReg, pcNext;
  logic                     changedReg, changedNext;
  logic                     misalignReg, misalignNext;
  logic [15:0]              countReg, countNext;

  logic [DATAWIDTH_BUS-1:0] dispExt;
  logic [DATAWIDTH_BUS-1:0] branchOffset;
  logic [DATAWIDTH_BUS-1:0] rawTarget;
  logic                     loadAccept;
  logic                     misalignNew;

  // Word displacement -> byte offset: sign extend, then scale by 4.
  assign dispExt      = {{(DATAWIDTH_BUS-DATAWIDTH_DISP){SC_PCSeq_Disp_In[DATAWIDTH_DISP-1]}},
                         SC_PCSeq_Disp_In};
  assign branchOffset = {dispExt[DATAWIDTH_BUS-3:0], 2'b00};

  // Raw (unaligned) candidate for the selected source.
  always_comb begin
    rawTarget = pcReg;
    case (SC_PCSeq_Sel_In)
      SEL_STEP:   rawTarget = pcReg + SC_PCSeq_Step_In;
      SEL_BRANCH: rawTarget = pcReg + branchOffset;
      SEL_JUMP:   rawTarget = SC_PCSeq_Target_In;
      default:    rawTarget = pcReg;
    endcase
  end

  // Next-state selection: trap > stall > sel.
  always_comb begin
    pcNext      = pcReg;
    loadAccept  = 1'b0;
    misalignNew = 1'b0;
    if (SC_PCSeq_Trap_In) begin
      pcNext     = TRAP_ALIGNED;
      loadAccept = 1'b1;
    end else if (!SC_PCSeq_Stall_In && (SC_PCSeq_Sel_In != SEL_HOLD)) begin
      pcNext      = {rawTarget[DATAWIDTH_BUS-1:2], 2'b00};
      loadAccept  = 1'b1;
      misalignNew = (rawTarget[1:0] != 2'b00);
    end
  end

  always_comb begin
    changedNext = loadAccept;
    // A fresh misalignment on this edge beats a clear request.
    if (misalignNew)
      misalignNext = 1'b1;
    else if (SC_PCSeq_ClrErr_In)
      misalignNext = 1'b0;
    else
      misalignNext = misalignReg;
    if (loadAccept && (countReg != 16'hFFFF))
      countNext = countReg + 16'd1;
    else
      countNext = countReg;
  end

  always_ff @(negedge SC_PCSeq_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      pcReg       <= RESET_VECTOR;
      changedReg  <= 1'b0;
      misalignReg <= 1'b0;
      countReg    <= 16'h0000;
    end else begin
      pcReg       <= pcNext;
      changedReg  <= changedNext;
      misalignReg <= misalignNext;
      countReg    <= countNext;
    end
  end

  assign SC_PCSeq_PC_Out       = pcReg;
  assign SC_PCSeq_PCNext_Out   = pcReg + SC_PCSeq_Step_In;
  assign SC_PCSeq_Changed_Out  = changedReg;
  assign SC_PCSeq_Misalign_Out = misalignReg;
  assign SC_PCSeq_Count_Out    = countReg;

endmodule

// File: tb/tb_sc_pc_sequencer.sv
// Bench for sc_pc_sequencer: directed stimulus, a behavioural model that
// derives PC/flags/count from the select rules with plain arithmetic, a
// per-cycle compare process, and literal checks at the key points.
module tb_sc_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] step;
  logic [21:0] disp;
  logic [31:0] target;
  logic [1:0]  sel;
  logic        stall;
  logic        trap;
  logic        clrErr;
  logic [31:0] dutPc;
  logic [31:0] dutPcNext;
  logic        dutChanged;
  logic        dutMisalign;
  logic [15:0] dutCount;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [31:0] mPc       = 32'h0;
  logic        mChanged  = 1'b0;
  logic        mMisalign = 1'b0;
  int          mCount    = 0;

  sc_pc_sequencer dut (
    .SC_PCSeq_CLOCK_50          (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .SC_PCSeq_Step_In           (step),
    .SC_PCSeq_Disp_In           (disp),
    .SC_PCSeq_Target_In         (target),
    .SC_PCSeq_Sel_In            (sel),
    .SC_PCSeq_Stall_In          (stall),
    .SC_PCSeq_Trap_In           (trap),
    .SC_PCSeq_ClrErr_In         (clrErr),
    .SC_PCSeq_PC_Out            (dutPc),
    .SC_PCSeq_PCNext_Out        (dutPcNext),
    .SC_PCSeq_Changed_Out       (dutChanged),
    .SC_PCSeq_Misalign_Out      (dutMisalign),
    .SC_PCSeq_Count_Out         (dutCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one falling edge of the rules to the model.
  task automatic modelEdge();
    longint raw;
    bit     load;
    bit     misNew;
    load   = 0;
    misNew = 0;
    if (trap) begin
      mPc  = 32'h00000800;
      load = 1;
    end else if (!stall && sel != 2'd0) begin
      case (sel)
        2'd1:    raw = longint'(mPc) + longint'(step);
        2'd2:    raw = longint'(mPc) + longint'($signed(disp)) * 4;
        default: raw = longint'(target);
      endcase
      raw    = raw & 64'hFFFF_FFFF;
      misNew = (raw % 4) != 0;
      mPc    = 32'(raw - (raw % 4));
      load   = 1;
    end
    mChanged = load;
    if (misNew)      mMisalign = 1'b1;
    else if (clrErr) mMisalign = 1'b0;
    if (load && mCount < 65535) mCount++;
  endtask

  task automatic modelReset();
    mPc       = 32'h0;
    mChanged  = 1'b0;
    mMisalign = 1'b0;
    mCount    = 0;
  endtask

  // Called at a rising edge; returns at the next rising edge.
  task automatic cyc(input logic [1:0] s, input logic st, input logic tr, input logic ce,
                     input logic [31:0] stp, input logic [31:0] tgt, input logic [21:0] d);
    #1;
    sel = s; stall = st; trap = tr; clrErr = ce;
    step = stp; target = tgt; disp = d;
    @(negedge clk);
    modelEdge();
    @(posedge clk);
  endtask

  // Compare process: outputs are stable at every rising edge.
  always @(posedge clk) begin
    chk("pc",       dutPc,                 mPc);
    chk("pcnext",   dutPcNext,             mPc + step);
    chk("changed",  {31'b0, dutChanged},   {31'b0, mChanged});
    chk("misalign", {31'b0, dutMisalign},  {31'b0, mMisalign});
    chk("count",    {16'b0, dutCount},     32'(mCount));
  end

  // Async reset between edges, checked before any clock edge arrives.
  task automatic asyncReset();
    #2;
    rst = 1'b1; sel = 2'd0; stall = 1'b0; trap = 1'b0; clrErr = 1'b0;
    modelReset();
    #1;
    chk("arst_pc",       dutPc,                32'h0);
    chk("arst_count",    {16'b0, dutCount},    32'h0);
    chk("arst_misalign", {31'b0, dutMisalign}, 32'h0);
    chk("arst_changed",  {31'b0, dutChanged},  32'h0);
    @(posedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] frozenPc;
  logic [15:0] frozenCount;

  initial begin
    rst = 1'b1; step = 32'd4; disp = '0; target = '0;
    sel = 2'd0; stall = 1'b0; trap = 1'b0; clrErr = 1'b0;
    @(posedge clk);
    chk("reset_pc", dutPc, 32'h0);
    @(posedge clk);
    rst = 1'b0;

    // Sequential stepping
    cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("step1_pc", dutPc, 32'h4);
    cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("step2_pc", dutPc, 32'h8);
    cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("step3_pc",      dutPc,               32'hC);
    chk("step3_count",   {16'b0, dutCount},   32'd3);
    chk("step3_pcnext",  dutPcNext,           32'h10);
    chk("step3_changed", {31'b0, dutChanged}, 32'd1);

    // Relative branches from 0x100
    cyc(2'd3, 0, 0, 0, 32'd4, 32'h100, 22'h0);
    cyc(2'd2, 0, 0, 0, 32'd4, 32'h0, 22'h3FFFFE);
    chk("branch_back_pc", dutPc, 32'hF8);
    cyc(2'd2, 0, 0, 0, 32'd4, 32'h0, 22'h000003);
    chk("branch_fwd_pc",  dutPc, 32'h104);
    chk("branch_mis",     {31'b0, dutMisalign}, 32'd0);

    // Misaligned jump, clear, then clear racing a new misalignment
    cyc(2'd3, 0, 0, 0, 32'd4, 32'h203, 22'h0);
    chk("jmp_mis_pc",  dutPc, 32'h200);
    chk("jmp_mis_flag", {31'b0, dutMisalign}, 32'd1);
    cyc(2'd0, 0, 0, 1, 32'd4, 32'h0, 22'h0);
    chk("clr_mis_flag", {31'b0, dutMisalign}, 32'd0);
    chk("clr_changed",  {31'b0, dutChanged},  32'd0);
    cyc(2'd3, 0, 0, 1, 32'd4, 32'h203, 22'h0);
    chk("clr_vs_new_mis", {31'b0, dutMisalign}, 32'd1);

    // Stall freezes PC and count; trap overrides stall
    frozenPc    = dutPc;
    frozenCount = dutCount;
    for (int i = 0; i < 4; i++) cyc(2'd1, 1, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("stall_pc",      dutPc,               frozenPc);
    chk("stall_count",   {16'b0, dutCount},   {16'b0, frozenCount});
    chk("stall_pc_lit",  dutPc,               32'h200);
    chk("stall_cnt_lit", {16'b0, dutCount},   32'd8);
    chk("stall_changed", {31'b0, dutChanged}, 32'd0);
    cyc(2'd1, 1, 1, 0, 32'd4, 32'h0, 22'h0);
    chk("trap_pc",      dutPc,               32'h800);
    chk("trap_changed", {31'b0, dutChanged}, 32'd1);
    chk("trap_count",   {16'b0, dutCount},   32'd9);

    // Wraparound without error
    cyc(2'd0, 0, 0, 1, 32'd4, 32'h0, 22'h0);
    cyc(2'd3, 0, 0, 0, 32'd4, 32'hFFFFFFFC, 22'h0);
    chk("wrap_pre_next", dutPcNext, 32'h0);
    cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("wrap_pc",  dutPc, 32'h0);
    chk("wrap_mis", {31'b0, dutMisalign}, 32'd0);

    // Counter saturation
    asyncReset();
    for (int i = 0; i < 65534; i++) cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("count_fffe", {16'b0, dutCount}, 32'hFFFE);
    for (int i = 0; i < 3; i++) cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("count_sat", {16'b0, dutCount}, 32'hFFFF);

    // Mid-stream async reset at PC=40 with the error flag set
    asyncReset();
    cyc(2'd3, 0, 0, 0, 32'd4, 32'h43, 22'h0);
    chk("pre_arst_pc",  dutPc, 32'h40);
    chk("pre_arst_mis", {31'b0, dutMisalign}, 32'd1);
    asyncReset();
    cyc(2'd1, 0, 0, 0, 32'd4, 32'h0, 22'h0);
    chk("post_arst_pc", dutPc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_pc_sequencer.md
Name: sc_pc_sequencer

Overview:
- Program-counter stage sitting directly downstream of the fixed-constant registers.
- It consumes the increment constant (normally 32'h00000004) from a fixed register and holds the current PC.
- Each accepted cycle it computes the next PC: hold, sequential step, PC-relative branch, absolute jump, or trap vector.
- Its outputs drive the instruction-memory address bus and the datapath's PC read path.

Parameters:
- DATAWIDTH_BUS, 32, width of PC, step, and target buses.
- DATAWIDTH_DISP, 22, width of the signed word displacement for relative branches.
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- TRAP_VECTOR, 32'h00000800, PC value loaded on trap.

Ports:
- SC_PCSeq_CLOCK_50  input  1  system clock; all registers update on the falling edge.
- SC_RegGENERAL_RESET_InHigh  input  1  reset; asynchronous, active-high.
- SC_PCSeq_Step_In  input  DATAWIDTH_BUS  increment constant from the fixed register.
- SC_PCSeq_Disp_In  input  DATAWIDTH_DISP  signed word displacement.
- SC_PCSeq_Target_In  input  DATAWIDTH_BUS  absolute jump target.
- SC_PCSeq_Sel_In  input  2  next-PC select: 00 HOLD, 01 STEP, 10 BRANCH, 11 JUMP.
- SC_PCSeq_Stall_In  input  1  when high, PC holds regardless of Sel.
- SC_PCSeq_Trap_In  input  1  forces a load of TRAP_VECTOR.
- SC_PCSeq_ClrErr_In  input  1  synchronous clear of the misalignment flag.
- SC_PCSeq_PC_Out  output  DATAWIDTH_BUS  current PC (registered).
- SC_PCSeq_PCNext_Out  output  DATAWIDTH_BUS  combinational PC+Step, for link/call writeback.
- SC_PCSeq_Changed_Out  output  1  registered; high one cycle after any accepted load.
- SC_PCSeq_Misalign_Out  output  1  sticky misalignment error flag.
- SC_PCSeq_Count_Out  output  16  accepted-load counter, saturating.

Behaviour:
- Reset (async, any time, including mid-operation):
  - PC = RESET_VECTOR, Changed = 0, Misalign = 0, Count = 0.
  - Reset dominates all inputs.
- Per-edge priority: reset > Trap > Stall > Sel.
- Trap=1: PC <= TRAP_VECTOR with bits[1:0] forced to 00. Trap overrides Stall. Counts as an accepted load.
- Stall=1 with Trap=0: PC, Count, and Misalign hold; Changed <= 0. ClrErr is still honoured.
- Sel with Stall=0 and Trap=0:
  - HOLD: PC unchanged, not an accepted load.
  - STEP: raw = PC + Step_In.
  - BRANCH: raw = PC + (sign_extend(Disp_In) << 2).
  - JUMP: raw = Target_In.
- Arithmetic is modulo 2^DATAWIDTH_BUS. Overflow wraps silently (e.g. FFFFFFFC + 4 = 00000000) and does not raise an error.
- Alignment rule for STEP/BRANCH/JUMP:
  - PC <= {raw[W-1:2], 2'b00}.
  - If raw[1:0] != 00, Misalign <= 1 on the same edge.
- Misalign is sticky. It is cleared only by reset or by ClrErr=1 with no new misalignment on that edge; a new misalignment wins over ClrErr.
- Changed <= 1 on any edge with an accepted load (Trap, STEP, BRANCH, JUMP), else 0. A load whose value equals the old PC still asserts Changed.
- Count increments by 1 per accepted load and saturates at 16'hFFFF.
- PCNext_Out = PC_Out + Step_In, combinational, same modulo rule, no alignment forcing. Valid in every state, including stall.
- Latency: a select presented before a falling edge is visible on PC_Out immediately after that edge (1 cycle).

Test Plan:
- Reset release, Step=4, Sel=01 for 3 edges -> PC 0,4,8,C; Changed=1 after each edge; Count=3; PCNext=10 after the third edge.
- PC=100, Sel=10, Disp=22'h3FFFFE (-2) -> PC=F8. Then Disp=22'h000003 -> PC=104. Misalign stays 0.
- Sel=11, Target=00000203 -> PC=00000200, Misalign=1. Next edge ClrErr=1, Sel=00 -> Misalign=0, Changed=0. Repeat with ClrErr=1 and a misaligned target on the same edge -> Misalign stays 1.
- Stall=1, Sel=01 for 4 edges -> PC and Count frozen, Changed=0. Trap=1 while stalled -> PC=00000800, Changed=1.
- PC=FFFFFFFC, Sel=01, Step=4 -> PC=00000000, no error. Count preloaded to FFFE by driving 65534 accepted loads, then 3 more loads -> Count=FFFF.
- Assert reset asynchronously between edges mid-stream at PC=40 -> PC=RESET_VECTOR, Count=0, Misalign=0 immediately, without waiting for a clock edge.
